// File: rtl/dual_port_shared_ram_pkg.sv
// Shared constants for the MPEG control/worker mailbox RAM.
// Both cores map this RAM at 0x4xxxxxxx and use byte-address bits [12:2] as the word address.
package dual_port_shared_ram_pkg;

  localparam int SHARED_RAM_ADDR_WIDTH = 11;
  localparam int SHARED_RAM_DATA_WIDTH = 32;

  // One write enable per 8-bit lane of a word.
  function automatic int be_width_of(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/byte_lane_dp_ram.sv
// One 8-bit lane of the shared RAM.
// Two read-first ports. The top guarantees that both ports never write the same address in one cycle.
module byte_lane_dp_ram #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rd_clr,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [7:0]            din1,
  input  logic                  we1,
  output logic [7:0]            dout1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [7:0]            din2,
  input  logic                  we2,
  output logic [7:0]            dout2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  // Both writes are in one process, which keeps the array single-driven.
  // Port 1 is written last, so it would also win a same-address clash.
  always_ff @(posedge clk) begin
    if (we2) mem[addr2] <= din2;
    if (we1) mem[addr1] <= din1;
  end

  // The reads sample the array before this edge's writes land, which gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      dout1 <= '0;
      dout2 <= '0;
    end else begin
      dout1 <= mem[addr1];
      dout2 <= mem[addr2];
    end
  end

endmodule

// File: rtl/dual_port_shared_ram.sv
// True dual-port, byte-writable mailbox RAM shared by the MPEG control core (port 1) and a macroblock worker (port 2).
// The RAM is built from per-byte-lane banks. Where both ports enable the same lane of the same address, port 1 wins.
module dual_port_shared_ram
  import dual_port_shared_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = SHARED_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SHARED_RAM_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_WIDTH-1:0]      addr1,
  input  logic [DATA_WIDTH-1:0]      data_in1,
  input  logic                       we1,
  input  logic [DATA_WIDTH/8-1:0]    be1,
  output logic [DATA_WIDTH-1:0]      data_out1,
  input  logic [ADDR_WIDTH-1:0]      addr2,
  input  logic [DATA_WIDTH-1:0]      data_in2,
  input  logic                       we2,
  input  logic [DATA_WIDTH/8-1:0]    be2,
  output logic [DATA_WIDTH-1:0]      data_out2
);

  localparam int BE_WIDTH = be_width_of(DATA_WIDTH);

  logic wr_en1;
  logic wr_en2;
  logic same_addr;
  logic rd_clr;

  // Writes are dropped while reset is asserted. The reset value of the read registers is applied inside each lane.
  assign wr_en1    = we1 & reset_n;
  assign wr_en2    = we2 & reset_n;
  assign same_addr = (addr1 == addr2);
  assign rd_clr    = ~reset_n;

  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
    logic lane_we1;
    logic lane_we2;

    assign lane_we1 = wr_en1 & be1[i];
    assign lane_we2 = wr_en2 & be2[i] & ~(lane_we1 & same_addr);

    byte_lane_dp_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rd_clr(rd_clr),
      .addr1 (addr1),
      .din1  (data_in1[8*i +: 8]),
      .we1   (lane_we1),
      .dout1 (data_out1[8*i +: 8]),
      .addr2 (addr2),
      .din2  (data_in2[8*i +: 8]),
      .we2   (lane_we2),
      .dout2 (data_out2[8*i +: 8])
    );
  end

endmodule

// File: tb/tb_dual_port_shared_ram.sv
// Directed bench for dual_port_shared_ram: reset, byte enables, read-first, collisions, and streaming traffic.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same point, after the edge has settled.
module tb_dual_port_shared_ram;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] addr1, addr2;
  logic [DW-1:0] data_in1, data_in2;
  logic          we1, we2;
  logic [BW-1:0] be1, be2;
  logic [DW-1:0] data_out1, data_out2;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  dual_port_shared_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .addr1    (addr1),
    .data_in1 (data_in1),
    .we1      (we1),
    .be1      (be1),
    .data_out1(data_out1),
    .addr2    (addr2),
    .data_in2 (data_in2),
    .we2      (we2),
    .be2      (be2),
    .data_out2(data_out2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we1 = 1'b0; we2 = 1'b0; be1 = '0; be2 = '0;
  endtask

  task automatic drive1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    addr1 = a; data_in1 = d; be1 = be; we1 = 1'b1;
  endtask

  task automatic drive2(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    addr2 = a; data_in2 = d; be2 = be; we2 = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle();
    addr1 = '0; addr2 = '0; data_in1 = '0; data_in2 = '0;
    tick(); tick();
    checks++;
    if (data_out1 !== 32'h0) begin errors++; $display("FAIL reset_out1 got %h exp %h", data_out1, 32'h0); end
    checks++;
    if (data_out2 !== 32'h0) begin errors++; $display("FAIL reset_out2 got %h exp %h", data_out2, 32'h0); end
    reset_n = 1'b1;
    drive1(11'd5, 32'hDEADBEEF, 4'hF);
    tick();
    idle(); reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (data_out1 !== 32'h0) begin errors++; $display("FAIL midreset_out1 got %h exp %h", data_out1, 32'h0); end
      checks++;
      if (data_out2 !== 32'h0) begin errors++; $display("FAIL midreset_out2 got %h exp %h", data_out2, 32'h0); end
    end
    reset_n = 1'b1; addr2 = 11'd5;
    tick();
    checks++;
    if (data_out2 !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_keep got %h exp %h", data_out2, 32'hDEADBEEF); end
  endtask

  task automatic test_byte_enables();
    drive1(11'h10, 32'h11223344, 4'hF);
    tick(); idle();
    drive2(11'h10, 32'hAABBCCDD, 4'b0101);
    tick(); idle();
    // A write with every byte enable clear must leave the word unchanged.
    drive1(11'h10, 32'hFFFFFFFF, 4'b0000);
    tick(); idle();
    addr1 = 11'h10; addr2 = 11'h10;
    tick();
    checks++;
    if (data_out1 !== 32'h11BB33DD) begin errors++; $display("FAIL be_out1 got %h exp %h", data_out1, 32'h11BB33DD); end
    checks++;
    if (data_out2 !== 32'h11BB33DD) begin errors++; $display("FAIL be_out2 got %h exp %h", data_out2, 32'h11BB33DD); end
  endtask

  task automatic test_read_first();
    drive1(11'd7, 32'h1, 4'hF);
    tick(); idle();
    addr1 = 11'd0;
    drive2(11'd7, 32'h2, 4'hF);
    tick(); idle();
    checks++;
    if (data_out2 !== 32'h1) begin errors++; $display("FAIL rdfirst_old got %h exp %h", data_out2, 32'h1); end
    tick();
    checks++;
    if (data_out2 !== 32'h2) begin errors++; $display("FAIL rdfirst_new got %h exp %h", data_out2, 32'h2); end
  endtask

  task automatic test_collision();
    drive1(11'h7FF, 32'h0, 4'hF);
    tick(); idle();
    drive1(11'h7FF, 32'hAAAAAAAA, 4'b0011);
    drive2(11'h7FF, 32'h55555555, 4'b0110);
    tick(); idle();
    checks++;
    if (data_out1 !== 32'h0) begin errors++; $display("FAIL coll_old1 got %h exp %h", data_out1, 32'h0); end
    checks++;
    if (data_out2 !== 32'h0) begin errors++; $display("FAIL coll_old2 got %h exp %h", data_out2, 32'h0); end
    tick();
    checks++;
    if (data_out1 !== 32'h0055AAAA) begin errors++; $display("FAIL coll_new1 got %h exp %h", data_out1, 32'h0055AAAA); end
    checks++;
    if (data_out2 !== 32'h0055AAAA) begin errors++; $display("FAIL coll_new2 got %h exp %h", data_out2, 32'h0055AAAA); end
  endtask

  task automatic test_write_in_reset();
    drive1(11'd3, 32'h0, 4'hF);
    tick(); idle();
    reset_n = 1'b0;
    drive1(11'd3, 32'hCAFEF00D, 4'hF);
    tick(); idle();
    reset_n = 1'b1; addr1 = 11'd3; addr2 = 11'd3;
    tick();
    checks++;
    if (data_out1 !== 32'h0) begin errors++; $display("FAIL rst_drop1 got %h exp %h", data_out1, 32'h0); end
    checks++;
    if (data_out2 !== 32'h0) begin errors++; $display("FAIL rst_drop2 got %h exp %h", data_out2, 32'h0); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp;
    for (int k = 0; k <= (1 << AW); k++) begin
      if (k < (1 << AW)) drive1(AW'(k), DW'(k), 4'hF);
      else               we1 = 1'b0;
      if (k > 0) begin
        addr2 = AW'(k - 1);
        exp_q.push_back(DW'(k - 1));
      end
      tick();
      if (k > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (data_out2 !== exp) begin
          errors++;
          $display("FAIL stream_rd addr %0d got %h exp %h", k - 1, data_out2, exp);
        end
      end
    end
    idle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_q left %0d exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_byte_enables();
    test_read_first();
    test_collision();
    test_write_in_reset();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_shared_ram.md
Name: dual_port_shared_ram

Overview:
True dual-port, byte-writable synchronous SRAM that acts as the mailbox/shared memory between the main MPEG control core (port 1) and a macroblock worker core (port 2). Both ports read and write independently on a single clock. It is mapped at 0x4xxxxxxx in each core's data space, word-addressed via address bits [12:2]. The memory is built from per-byte-lane banks so it infers block RAM.

Parameters:
ADDR_WIDTH, 11, word address width; depth = 2**ADDR_WIDTH (2048 words).
DATA_WIDTH, 32, word width; must be a multiple of 8.
BE_WIDTH, DATA_WIDTH/8, number of byte enables (derived, not overridable).

Ports:
clk  input  1  single clock for both ports.
reset_n  input  1  synchronous, active-low reset.
addr1  input  ADDR_WIDTH  port 1 word address.
data_in1  input  DATA_WIDTH  port 1 write data.
we1  input  1  port 1 write strobe.
be1  input  BE_WIDTH  port 1 byte enables; bit i covers data bits [8i+7:8i].
data_out1  output  DATA_WIDTH  port 1 registered read data.
addr2  input  ADDR_WIDTH  port 2 word address.
data_in2  input  DATA_WIDTH  port 2 write data.
we2  input  1  port 2 write strobe.
be2  input  BE_WIDTH  port 2 byte enables.
data_out2  output  DATA_WIDTH  port 2 registered read data.

Behaviour:
- Reset: while reset_n=0 at a rising edge, data_out1 and data_out2 are set to 0 and all writes are suppressed. Memory contents are not cleared and are undefined at power-up.
- Read: every cycle, each port registers mem[addrN] into data_outN. Latency is 1 cycle. There is no read enable; the output updates every cycle.
- Write: at a rising edge with weN=1 and reset_n=1, for each lane i with beN[i]=1, mem[addrN] lane i takes data_inN lane i. Lanes with beN[i]=0 are unchanged. we=1 with be=0 is a no-op.
- Same-port read-during-write (read-first): data_outN shows the contents before the write. The new value is visible one cycle later.
- Cross-port read of an address the other port writes in the same cycle: returns the old data.
- Both ports write the same address in the same cycle: lanes enabled on only one port take that port's data. For lanes enabled on both ports, port 1 wins. Result is deterministic, with no X.
- Address wrap: addresses are exactly ADDR_WIDTH bits, so no out-of-range condition exists.
- Reset mid-operation: a write presented in the same cycle as reset_n=0 is dropped. Reads resume on the first edge after reset_n returns to 1.
- Address decoding and the unit-index select are the caller's responsibility. This block sees only already-qualified we1/we2.

Decomposition:
- Shared package holds the default constants SHARED_RAM_ADDR_WIDTH=11 and SHARED_RAM_DATA_WIDTH=32.
- One sub-module, byte_lane_dp_ram: an 8-bit true dual-port bank with read-first ports.
- The top instantiates BE_WIDTH lanes via generate. It applies the port-1-priority collision rule by masking lane we2 when addr1==addr2 and we1&be1[i]. It also applies the reset gating of writes and outputs.

Test Plan:
1. Reset clears outputs: write 0xDEADBEEF @5 via port 1, assert reset_n=0 for 2 cycles -> data_out1 = data_out2 = 0 during reset; after release, reading @5 on port 2 returns 0xDEADBEEF.
2. Byte enables: port 1 writes 0x11223344 @0x10 with be=1111, then port 2 writes 0xAABBCCDD @0x10 with be=0101 -> next read on either port returns 0x11BB33DD.
3. Read-first on the same port: @7 holds 0x1, port 2 writes 0x2 @7 with be=1111 while reading @7 -> data_out2=0x1 on that edge, 0x2 on the next.
4. Cross-port collision: both ports write @0x7FF in the same cycle, port 1 0xAAAAAAAA be=0011, port 2 0x55555555 be=0110 -> @0x7FF = 0x0055AAAA over the prior 0x00000000; port 1 wins lane 1.
5. Write during reset is dropped: reset_n=0 with we1=1, 0xCAFEF00D @3 (prior 0x0) -> after reset, read @3 = 0x0.
6. Independent concurrent traffic: port 1 streams writes 0..2047 with data=addr while port 2 reads the addresses behind it -> every port-2 read returns its address one cycle after issue.
